// File: rtl/sba_initiator.sv
// sba_initiator: debug system-bus-access initiator. It takes one read/write
// command at a time from the debug module and runs it as a single arilla bus
// transaction with sub-word sizing, byte-lane steering, an alignment check
// and optional address auto-increment.
// Optional feature: define SBA_INITIATOR__TIMEOUT_EN to bound the wait for
// bus_done to TimeoutCycles cycles. When it fires, the response is rsp_err = 2.
module sba_initiator #(
   parameter int unsigned DataWidth        = 32,
   parameter int unsigned ByteAddressWidth = 32,
   parameter int unsigned ByteSize         = 8,
   parameter int unsigned TimeoutCycles    = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          cmd_write,
   input  logic                          cmd_addr_load,
   input  logic [ByteAddressWidth-1:0]   cmd_addr,
   input  logic [1:0]                    cmd_size,
   input  logic                          cmd_autoinc,
   input  logic [DataWidth-1:0]          cmd_wdata,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [DataWidth-1:0]          rsp_rdata,
   output logic [1:0]                    rsp_err,
   output logic [ByteAddressWidth-1:0]   bus_address,
   output logic                          bus_read,
   output logic                          bus_write,
   output logic [DataWidth/ByteSize-1:0] bus_byte_enable,
   output logic [DataWidth-1:0]          bus_data_out,
   input  logic [DataWidth-1:0]          bus_data_in,
   input  logic                          bus_done
);

   localparam int unsigned NumLanes = DataWidth / ByteSize;
   localparam int unsigned OffWidth = $clog2(NumLanes);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RSP  = 2'd3
   } state_t;

   // Size 3 is illegal, and so is any access wider than the bus. Otherwise
   // the lane offset must be a multiple of the access size.
   function automatic logic misaligned(input logic [1:0] size, input logic [OffWidth-1:0] off);
      int unsigned nbytes;
      int unsigned off_u;
      nbytes = 32'd1 << size;
      off_u  = 32'(off);
      misaligned = (size == 2'd3) || (nbytes > NumLanes) ||
                   ((off_u & (nbytes - 32'd1)) != 32'd0);
   endfunction

   // Byte-lane mask for an access of 2^size bytes starting at lane off.
   function automatic logic [NumLanes-1:0] lane_mask(input logic [1:0] size, input logic [OffWidth-1:0] off);
      logic [NumLanes-1:0] base;
      for (int unsigned i = 0; i < NumLanes; i++) begin
         base[i] = (i < (32'd1 << size));
      end
      lane_mask = base << off;
   endfunction

   // Bit mask that keeps the low 2^size bytes of a right-aligned value.
   function automatic logic [DataWidth-1:0] size_mask(input logic [1:0] size);
      logic [DataWidth-1:0] m;
      for (int unsigned i = 0; i < DataWidth; i++) begin
         m[i] = (i < ((32'd1 << size) * ByteSize));
      end
      size_mask = m;
   endfunction

   state_t                      state_r;
   state_t                      next_state_s;
   logic [ByteAddressWidth-1:0] addr_r;
   logic [ByteAddressWidth-1:0] eff_addr_s;
   logic [OffWidth-1:0]         eff_off_s;
   logic [OffWidth-1:0]         cur_off_r;
   logic [1:0]                  size_r;
   logic                        write_r;
   logic                        autoinc_r;
   logic                        bad_s;
   logic                        timeout_s;
   logic [DataWidth-1:0]        rdata_s;

   logic [ByteAddressWidth-1:0] bus_address_r;
   logic                        bus_read_r;
   logic                        bus_write_r;
   logic [NumLanes-1:0]         bus_be_r;
   logic [DataWidth-1:0]        bus_data_out_r;
   logic [DataWidth-1:0]        rsp_rdata_r;
   logic [1:0]                  rsp_err_r;

   assign eff_addr_s = cmd_addr_load ? cmd_addr : addr_r;
   assign eff_off_s  = eff_addr_s[OffWidth-1:0];
   assign bad_s      = misaligned(cmd_size, eff_off_s);
   assign rdata_s    = (bus_data_in >> (32'(cur_off_r) * ByteSize)) & size_mask(size_r);

`ifdef SBA_INITIATOR__TIMEOUT_EN
   localparam int unsigned CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;

   logic [CntWidth-1:0] cnt_r;

   // The counter has the value n-1 in the n-th REQ/WAIT cycle. Expiry is the TimeoutCycles-th cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if ((state_r == REQ) || (state_r == WAIT)) begin
         cnt_r <= cnt_r + {{(CntWidth-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= '0;
      end
   end

   assign timeout_s = (cnt_r == CntWidth'(TimeoutCycles - 32'd1));
`else
   assign timeout_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic. If bus_done arrives in the expiry cycle, it wins over the timeout.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (cmd_valid) begin
               next_state_s = bad_s ? RSP : REQ;
            end else begin
               next_state_s = IDLE;
            end
         end
         REQ, WAIT: begin
            if (bus_done || timeout_s) begin
               next_state_s = RSP;
            end else begin
               next_state_s = WAIT;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = RSP;
            end
         end
         default: next_state_s = IDLE;
      endcase
   end

   // Datapath: latch the command, drive the bus, capture the response and
   // keep the internal address.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_r         <= '0;
         cur_off_r      <= '0;
         size_r         <= 2'd0;
         write_r        <= 1'b0;
         autoinc_r      <= 1'b0;
         bus_address_r  <= '0;
         bus_read_r     <= 1'b0;
         bus_write_r    <= 1'b0;
         bus_be_r       <= '0;
         bus_data_out_r <= '0;
         rsp_rdata_r    <= '0;
         rsp_err_r      <= 2'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (cmd_valid) begin
                  if (cmd_addr_load) begin
                     addr_r <= cmd_addr;
                  end
                  cur_off_r <= eff_off_s;
                  size_r    <= cmd_size;
                  write_r   <= cmd_write;
                  autoinc_r <= cmd_autoinc;
                  if (bad_s) begin
                     rsp_err_r   <= 2'd1;
                     rsp_rdata_r <= '0;
                  end else begin
                     bus_address_r  <= {eff_addr_s[ByteAddressWidth-1:OffWidth], {OffWidth{1'b0}}};
                     bus_read_r     <= ~cmd_write;
                     bus_write_r    <= cmd_write;
                     bus_be_r       <= lane_mask(cmd_size, eff_off_s);
                     bus_data_out_r <= (cmd_wdata & size_mask(cmd_size)) << (32'(eff_off_s) * ByteSize);
                  end
               end
            end
            REQ, WAIT: begin
               bus_read_r  <= 1'b0;
               bus_write_r <= 1'b0;
               if (bus_done) begin
                  rsp_err_r      <= 2'd0;
                  rsp_rdata_r    <= write_r ? '0 : rdata_s;
                  bus_address_r  <= '0;
                  bus_be_r       <= '0;
                  bus_data_out_r <= '0;
                  if (autoinc_r) begin
                     addr_r <= addr_r + ({{(ByteAddressWidth-1){1'b0}}, 1'b1} << size_r);
                  end
               end else if (timeout_s) begin
                  rsp_err_r      <= 2'd2;
                  rsp_rdata_r    <= '0;
                  bus_address_r  <= '0;
                  bus_be_r       <= '0;
                  bus_data_out_r <= '0;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_err_r   <= 2'd0;
                  rsp_rdata_r <= '0;
               end
            end
            default: begin
               bus_read_r  <= 1'b0;
               bus_write_r <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready       = (state_r == IDLE);
   assign rsp_valid       = (state_r == RSP);
   assign rsp_rdata       = rsp_rdata_r;
   assign rsp_err         = rsp_err_r;
   assign bus_address     = bus_address_r;
   assign bus_read        = bus_read_r;
   assign bus_write       = bus_write_r;
   assign bus_byte_enable = bus_be_r;
   assign bus_data_out    = bus_data_out_r;

endmodule

// File: doc/sba_initiator.md
# sba_initiator

System-bus-access initiator for the debug path: accepts single read/write commands from the debug module over a valid/ready command channel and executes each one as a bus transaction on the arilla bus, in parallel with `rv_core` as a second initiator. Handles sub-word sizing, byte-lane steering, alignment checking, optional address auto-increment and optional response timeout. Instantiated in the system top and wired to the shared `arilla_bus_if` fields of the same names.

## Interface
- `DataWidth`, 32, bus data width in bits (power of two, ≥ 16)
- `ByteAddressWidth`, 32, byte address width
- `ByteSize`, 8, bits per byte lane
- `TimeoutCycles`, 255, max cycles waiting for `bus_done` (only with timeout compiled in)

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr_load`  in  1  1 = load internal address from `cmd_addr`; 0 = reuse internal address
- `cmd_addr`  in  ByteAddressWidth  byte address
- `cmd_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- `cmd_autoinc`  in  1  after a successful access, address += 2^size
- `cmd_wdata`  in  DataWidth  write data, right-aligned
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed
- `rsp_rdata`  out  DataWidth  read data, right-aligned, zero-extended; 0 for writes
- `rsp_err`  out  2  0 = ok, 1 = misaligned/illegal size, 2 = timeout
- `bus_address`  out  ByteAddressWidth  word-aligned address (low bits zero)
- `bus_read`  out  1  read strobe
- `bus_write`  out  1  write strobe
- `bus_byte_enable`  out  DataWidth/ByteSize  lane mask
- `bus_data_out`  out  DataWidth  lane-steered write data
- `bus_data_in`  in  DataWidth  read data from responder
- `bus_done`  in  1  responder completion

## Operation
- States: IDLE, REQ, WAIT, RSP.
- IDLE: `cmd_ready`=1. On handshake: effective address = `cmd_addr_load` ? `cmd_addr` : internal address; latch command. If `cmd_size`=3 or address not aligned to 2^size → RSP, `rsp_err`=1, no bus access. Else → REQ.
- REQ: assert `bus_read` or `bus_write` for exactly one cycle; `bus_byte_enable` = ((1<<2^size)-1) << addr[1:0]; `bus_data_out` = wdata shifted left by addr[1:0]·ByteSize. `bus_done` in REQ completes → RSP; else → WAIT.
- WAIT: address, byte enables, write data held; strobes low. `bus_done` → RSP.
- On completion: reads latch `bus_data_in` >> addr[1:0]·ByteSize, masked to size; `rsp_err`=0; if `cmd_autoinc`, internal address += 2^size (wraps modulo 2^ByteAddressWidth). Errors never update the internal address.
- RSP: `rsp_valid`=1, data/err stable until `rsp_ready`; then → IDLE.
- Internal address is also loaded (without increment) on any accepted command with `cmd_addr_load`=1, including erroring ones.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, all `bus_*` outputs 0, internal address 0.
- Reset mid-transaction: next cycle is IDLE with all outputs at reset values; a pending responder `bus_done` is ignored.
- Latency (handshake in cycle 0): strobe in cycle 1; with `bus_done` in cycle 1, `rsp_valid` in cycle 2. Misaligned: `rsp_valid` in cycle 1.
- `cmd_ready`=0 outside IDLE; one command outstanding, no pipelining. A new command is accepted at the earliest one cycle after the `rsp_ready` handshake.
- `bus_done` outside REQ/WAIT is ignored.

## Configuration
- `SBA_INITIATOR__TIMEOUT_EN` defined: a counter counts REQ+WAIT cycles. If `bus_done` has not arrived after `TimeoutCycles` cycles → RSP with `rsp_err`=2, `rsp_rdata`=0, no auto-increment. A `bus_done` in the expiry cycle wins (ok response).
- Not defined: WAIT waits indefinitely and `rsp_err`=2 is never produced.

## Test plan
- Word write 0xDEADBEEF @0x100, load=1, then word read @0x100 → bus_write 1 cycle with byte_enable 0xF; read `rsp_rdata`=0xDEADBEEF, err 0.
- Byte write 0xA5 @0x103 → `bus_address`=0x100, `bus_byte_enable`=0x8, `bus_data_out`=0xA5000000; byte read @0x103 → `rsp_rdata`=0x000000A5.
- Half read @0x101 → `rsp_err`=1, no bus strobe, `rsp_valid` cycle 1; size=3 → err 1.
- Autoinc: load 0x200, four word reads with load=0 → bus addresses 0x200, 0x204, 0x208, 0x20C; autoinc at 0xFFFFFFFC wraps to 0x0.
- Response backpressure: `rsp_ready` low 5 cycles → `rsp_valid`/data stable, `cmd_ready`=0 throughout.
- With timeout macro, `TimeoutCycles`=4, `bus_done` never → `rsp_err`=2 after 4 cycles; `rst` asserted in WAIT → IDLE with reset outputs next cycle.
